// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
//   Shares one quick_rs232 transmitter between NUM_REQ byte-stream requesters.
//   Arbitration is per packet: the granted requester keeps the line until it
//   flags its last byte, its req drops, or the copy handshake times out.
//   Build option: define TX_ARB_FIXED_PRIORITY_EN to replace round-robin with
//   lowest-index-wins priority (no last-owner pointer is built then).
module serial_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned HOLD_CYCLES  = 10,
  parameter int unsigned COPY_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 err_timeout,
  output logic                 tx_transaction,
  output logic [7:0]           tx_data,
  output logic                 tx_data_ready,
  input  logic                 tx_data_copied,
  input  logic                 tx_busy
);

  localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  localparam logic [16:0] CNT_TIMEOUT = 17'(COPY_TIMEOUT - 1);
  localparam logic [16:0] CNT_HOLD    = 17'(HOLD_CYCLES - 1);

  logic [2:0]         state;
  logic [IDXW-1:0]    winner;
  logic               last_flag;
  logic [16:0]        cnt;

  logic [NUM_REQ-1:0] cand;
  logic               pick_valid;
  logic [IDXW-1:0]    pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

  logic               sel_req;
  logic               sel_last;
  logic [7:0]         sel_data;

`ifdef TX_ARB_FIXED_PRIORITY_EN
  // Fixed priority: every pending request is a candidate, lowest index wins
  always_comb begin
    cand = req;
  end
`else
  logic [IDXW-1:0]    last_owner;
  logic [NUM_REQ-1:0] req_hi;

  // Round-robin: prefer requests above the last owner, else wrap to all requests
  always_comb begin
    req_hi = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_hi[k] = req[k] && (k > 32'(last_owner));
    end
    cand = (|req_hi) ? req_hi : req;
  end
`endif

  // Lowest set bit of the candidate vector, as index and one-hot
  always_comb begin
    pick_valid  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_valid && cand[k]) begin
        pick_valid     = 1'b1;
        pick_idx       = IDXW'(k);
        pick_onehot[k] = 1'b1;
      end
    end
  end

  // Current winner's request, last flag and data byte
  always_comb begin
    sel_req  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (32'(winner) == k) begin
        sel_req  = req[k];
        sel_last = req_last[k];
        sel_data = req_data[8*k +: 8];
      end
    end
  end

  // Arbitration and tx handshake state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      winner         <= '0;
      last_flag      <= 1'b0;
      cnt            <= '0;
      ack            <= '0;
      grant          <= '0;
      err_timeout    <= 1'b0;
      tx_transaction <= 1'b0;
      tx_data        <= '0;
      tx_data_ready  <= 1'b0;
`ifndef TX_ARB_FIXED_PRIORITY_EN
      last_owner     <= IDXW'(NUM_REQ - 1);
`endif
    end else begin
      ack         <= '0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant  <= pick_onehot;
            winner <= pick_idx;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (sel_req) begin
            tx_transaction <= 1'b1;
            tx_data        <= sel_data;
            ack            <= grant;
            last_flag      <= sel_last;
            cnt            <= '0;
            state          <= S_SEND;
          end else begin
            state <= S_DRAIN;
          end
        end
        S_SEND: begin
          tx_data_ready <= 1'b1;
          if (tx_data_copied) begin
            cnt   <= '0;
            state <= S_HOLD;
          end else if (cnt == CNT_TIMEOUT) begin
            tx_data_ready <= 1'b0;
            err_timeout   <= 1'b1;
            cnt           <= '0;
            state         <= S_DRAIN;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
        S_HOLD: begin
          if (cnt == CNT_HOLD) begin
            tx_data_ready <= 1'b0;
            cnt           <= '0;
            state         <= last_flag ? S_DRAIN : S_NEXT;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
        S_NEXT: begin
          state <= sel_req ? S_LOAD : S_DRAIN;
        end
        S_DRAIN: begin
          if (!tx_busy) begin
            tx_transaction <= 1'b0;
            grant          <= '0;
`ifndef TX_ARB_FIXED_PRIORITY_EN
            last_owner     <= winner;
`endif
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
